// File: rtl/pc_predict_pkg.sv
// Shared types for the PC prediction stage: 2-bit counter encodings
// and the BTB index/tag width helpers.
package pc_predict_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_t;

    // Index selects PC[idx_w+1:2]; the tag is everything above it.
    function automatic int unsigned btb_idx_w(input int unsigned entries);
        return $clog2(entries);
    endfunction

    function automatic int unsigned btb_tag_w(input int unsigned xlen,
                                              input int unsigned entries);
        return xlen - 2 - $clog2(entries);
    endfunction

    function automatic ctr_t ctr_inc(input ctr_t c);
        return (c == STRONG_T) ? STRONG_T : ctr_t'(c + 2'b01);
    endfunction

    function automatic ctr_t ctr_dec(input ctr_t c);
        return (c == STRONG_NT) ? STRONG_NT : ctr_t'(c - 2'b01);
    endfunction

endpackage

// File: rtl/pc_predict_stage_if.sv
// Bus between the PC stage, fetch/decode and the execute-stage resolution.
// slave: the PC stage; master: the surrounding pipeline.
interface pc_predict_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            stall;
    logic            ex_ctrl_valid;
    logic            ex_taken;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            clear_decoding_stage;
    logic            clear_execution_stage;

    modport master (
        output stall, ex_ctrl_valid, ex_taken, ex_pc, ex_target,
        output ex_pred_taken, ex_pred_target,
        input  pc, pred_taken, pred_target,
        input  clear_decoding_stage, clear_execution_stage
    );

    modport slave (
        input  stall, ex_ctrl_valid, ex_taken, ex_pc, ex_target,
        input  ex_pred_taken, ex_pred_target,
        output pc, pred_taken, pred_target,
        output clear_decoding_stage, clear_execution_stage
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit counters; only built with PC_PREDICT_BTB_EN.
// Ports: i_clk/i_rst, lookup (i_lookup_pc -> o_hit/o_taken/o_target), update (i_upd_*).
`ifdef PC_PREDICT_BTB_EN
module branch_target_buffer
    import pc_predict_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-3:0] i_lookup_pc,
    output logic            o_hit,
    output logic            o_taken,
    output logic [XLEN-1:0] o_target,
    input  logic            i_upd_valid,
    input  logic            i_upd_taken,
    input  logic [XLEN-3:0] i_upd_pc,
    input  logic [XLEN-1:0] i_upd_target
);
    localparam int unsigned IDX_W = btb_idx_w(BTB_ENTRIES);
    localparam int unsigned TAG_W = btb_tag_w(XLEN, BTB_ENTRIES);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        ctr_t             ctr;
    } btb_entry_t;

    btb_entry_t r_mem [BTB_ENTRIES];

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    btb_entry_t       w_lk;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    btb_entry_t       w_up;
    logic             w_up_hit;

    assign w_lk_idx = i_lookup_pc[IDX_W-1:0];
    assign w_lk_tag = i_lookup_pc[XLEN-3:IDX_W];
    assign w_lk     = r_mem[w_lk_idx];
    assign o_hit    = w_lk.valid && (w_lk.tag == w_lk_tag);
    assign o_taken  = o_hit && w_lk.ctr[1];
    assign o_target = w_lk.target;

    assign w_up_idx = i_upd_pc[IDX_W-1:0];
    assign w_up_tag = i_upd_pc[XLEN-3:IDX_W];
    assign w_up     = r_mem[w_up_idx];
    assign w_up_hit = w_up.valid && (w_up.tag == w_up_tag);

    // Tags and targets are left as-is on reset; a cleared valid bit hides them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_mem[IDX_W'(i)].valid <= 1'b0;
                r_mem[IDX_W'(i)].ctr   <= STRONG_NT;
            end
        end else if (i_upd_valid) begin
            if (i_upd_taken) begin
                r_mem[w_up_idx].valid  <= 1'b1;
                r_mem[w_up_idx].tag    <= w_up_tag;
                r_mem[w_up_idx].target <= i_upd_target;
                r_mem[w_up_idx].ctr    <= w_up_hit ? ctr_inc(w_up.ctr) : WEAK_T;
            end else if (w_up_hit) begin
                r_mem[w_up_idx].ctr <= ctr_dec(w_up.ctr);
            end
        end
    end

endmodule
`endif

// File: rtl/pc_predict_stage.sv
// Fetch PC register with BTB next-PC prediction, mispredict redirect and flush strobes.
// Ports: i_clk, i_rst (sync, active-high), bus (slave). Macro PC_PREDICT_BTB_EN enables the BTB.
module pc_predict_stage
    import pc_predict_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     BTB_ENTRIES  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    pc_predict_stage_if.slave bus
);
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_taken_target;
    logic [XLEN-1:0] w_redirect_pc;
    logic [XLEN-1:0] w_pred_target;
    logic            w_pred_taken;
    logic            w_mispredict;

    assign w_pc_plus4     = r_pc + XLEN'(4);
    // JALR targets may be odd; the LSB is dropped before fetch.
    assign w_taken_target = {bus.ex_target[XLEN-1:1], 1'b0};
    assign w_redirect_pc  = bus.ex_taken ? w_taken_target
                                         : bus.ex_pc + XLEN'(4);

    assign w_mispredict = bus.ex_ctrl_valid &&
        ((bus.ex_taken != bus.ex_pred_taken) ||
         (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));

`ifdef PC_PREDICT_BTB_EN
    logic            w_btb_hit;
    logic            w_btb_taken;
    logic [XLEN-1:0] w_btb_target;

    branch_target_buffer #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_lookup_pc  (r_pc[XLEN-1:2]),
        .o_hit        (w_btb_hit),
        .o_taken      (w_btb_taken),
        .o_target     (w_btb_target),
        .i_upd_valid  (bus.ex_ctrl_valid),
        .i_upd_taken  (bus.ex_taken),
        .i_upd_pc     (bus.ex_pc[XLEN-1:2]),
        .i_upd_target (w_taken_target)
    );

    // Counters only clear at the reset edge, so mask the prediction meanwhile.
    assign w_pred_taken  = w_btb_taken && !i_rst;
    assign w_pred_target = w_btb_hit ? w_btb_target : w_pc_plus4;
`else
    assign w_pred_taken  = 1'b0;
    assign w_pred_target = w_pc_plus4;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc <= RESET_VECTOR;
        end else if (w_mispredict) begin
            r_pc <= w_redirect_pc;
        end else if (!bus.stall) begin
            r_pc <= w_pred_taken ? w_pred_target : w_pc_plus4;
        end
    end

    assign bus.pc                    = r_pc;
    assign bus.pred_taken            = w_pred_taken;
    assign bus.pred_target           = w_pred_target;
    assign bus.clear_decoding_stage  = w_mispredict || i_rst;
    assign bus.clear_execution_stage = w_mispredict || i_rst;

endmodule
